// File: rtl/fifo_serial_pkg.sv
// Shared types and sizing helpers for the FIFO-draining serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_serial_pkg;

    // Transmitter sequencing states, in frame order.
    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    // Bits on the line per frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_width, input int parity_en);
        return data_width + parity_en + 2;
    endfunction

    // Width of the baud counter that runs 0 .. clks_per_bit-1.
    function automatic int baud_cnt_w(input int clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

    // Width of the data bit counter, able to hold the value data_width.
    function automatic int bit_cnt_w(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/fifo_serial_if.sv
// Read-side connection between the byte FIFO and its single reader.
// Latency: read data is valid the cycle after FIFO_rd.
// Backpressure: the reader pops only while FIFO_empty is low.
interface fifo_serial_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  FIFO_empty;
    logic [DATA_WIDTH-1:0] FIFO_data_out;
    logic                  FIFO_rd;

    // Reader side (the transmitter).
    modport master (
        output FIFO_rd,
        input  FIFO_empty,
        input  FIFO_data_out
    );

    // FIFO side.
    modport slave (
        input  FIFO_rd,
        output FIFO_empty,
        output FIFO_data_out
    );
endinterface

// File: rtl/fifo_serial_baud_cnt.sv
// Clearable modulo-CLKS_PER_BIT counter with terminal and pre-terminal flags.
// Latency: flags are decoded from the registered count (same cycle).
// Backpressure: none; counts every cycle unless cleared.
module fifo_serial_baud_cnt
    import fifo_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clr_i,
    output logic tc_o,
    output logic pre_tc_o
);
    localparam int CNT_W = baud_cnt_w(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign pre_tc_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 2));

    // Next count: hold at zero while cleared, wrap on terminal count.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops one FIFO word per frame and shifts it out: start, data LSB-first, opt. even parity, stop.
// Latency: 3 cycles from the IDLE pop decision to the first START cycle on tx.
// Backpressure: pops only in IDLE with enable high and FIFO non-empty; a frame never aborts.
module fifo_serial_tx
    import fifo_serial_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                enable,
    fifo_serial_if.master       fifo_if,
    output logic                tx,
    output logic                busy,
    output logic                frame_done
);
    localparam int BIT_W = bit_cnt_w(DATA_WIDTH);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  par_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic                  tx_q;
    logic                  rd_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  baud_clr;
    logic                  baud_tc;
    logic                  baud_pre_tc;

    // The baud counter only runs in the timed line states; elsewhere it is
    // held at zero so every timed state begins at count 0. Between timed
    // states the change happens on terminal count, where it wraps to 0.
    assign baud_clr = !(state_q == START || state_q == DATA ||
                        state_q == PARITY || state_q == STOP);

    fifo_serial_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk      (clk),
        .reset_L  (reset_L),
        .clr_i    (baud_clr),
        .tc_o     (baud_tc),
        .pre_tc_o (baud_pre_tc)
    );

    // Shift register contents after moving to the next data bit.
    always_comb begin
        shift_d = shift_q >> 1;
    end

    // Frame sequencer; tx, FIFO_rd, busy and frame_done are all registered
    // and set on the edge that enters the state they belong to.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (enable && !fifo_if.FIFO_empty) begin
                        state_q <= POP;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                POP: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    shift_q   <= fifo_if.FIFO_data_out;
                    par_q     <= ^fifo_if.FIFO_data_out;
                    bit_cnt_q <= '0;
                    tx_q      <= 1'b0;
                    state_q   <= START;
                end
                START: begin
                    if (baud_tc) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                            if (PARITY_EN != 0) begin
                                tx_q    <= par_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            shift_q <= shift_d;
                            tx_q    <= shift_d[0];
                        end
                    end
                end
                PARITY: begin
                    if (baud_tc) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    // Raise frame_done for exactly the final STOP cycle.
                    if (baud_pre_tc) begin
                        done_q <= 1'b1;
                    end
                    if (baud_tc) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx              = tx_q;
    assign busy            = busy_q;
    assign frame_done      = done_q;
    assign fifo_if.FIFO_rd = rd_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: two instances (no parity / even parity), CLKS_PER_BIT=4.
// Latency: frames are located by their start bit and checked cycle by cycle.
// Backpressure: a bench FIFO model feeds each instance and records every pop.
module tb_fifo_serial_tx;
    import fifo_serial_pkg::*;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset_L;
    logic en      [2];
    logic tx_w    [2];
    logic busy_w  [2];
    logic fd_w    [2];
    logic rd_w    [2];

    // Bench FIFO model: stimulus record plus read pointer and registered read data.
    logic [7:0] mem [2][64];
    int         wr_ptr  [2] = '{0, 0};
    int         rd_ptr  [2] = '{0, 0};
    int         rd_cnt  [2] = '{0, 0};
    int         bad_rd  [2] = '{0, 0};
    int         exp_idx [2] = '{0, 0};
    logic [7:0] dout    [2];

    int n_chk  = 0;
    int n_fail = 0;

    fifo_serial_if #(.DATA_WIDTH(DW)) if0 ();
    fifo_serial_if #(.DATA_WIDTH(DW)) if1 ();

    assign if0.FIFO_empty    = (wr_ptr[0] == rd_ptr[0]);
    assign if1.FIFO_empty    = (wr_ptr[1] == rd_ptr[1]);
    assign if0.FIFO_data_out = dout[0];
    assign if1.FIFO_data_out = dout[1];
    assign rd_w[0]           = if0.FIFO_rd;
    assign rd_w[1]           = if1.FIFO_rd;

    fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut0 (
        .clk        (clk),
        .reset_L    (reset_L),
        .enable     (en[0]),
        .fifo_if    (if0),
        .tx         (tx_w[0]),
        .busy       (busy_w[0]),
        .frame_done (fd_w[0])
    );

    fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut1 (
        .clk        (clk),
        .reset_L    (reset_L),
        .enable     (en[1]),
        .fifo_if    (if1),
        .tx         (tx_w[1]),
        .busy       (busy_w[1]),
        .frame_done (fd_w[1])
    );

    always #5 clk = ~clk;

    // FIFO read side: data appears the cycle after a pop; pops while empty are recorded.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rd_w[d]) begin
                rd_cnt[d] <= rd_cnt[d] + 1;
                if (wr_ptr[d] == rd_ptr[d]) begin
                    bad_rd[d] <= bad_rd[d] + 1;
                end else begin
                    dout[d]   <= mem[d][rd_ptr[d]];
                    rd_ptr[d] <= rd_ptr[d] + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        mem[d][wr_ptr[d]] = b;
        wr_ptr[d]         = wr_ptr[d] + 1;
    endtask

    // Expected line level for bit slot idx of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int pe, input int idx);
        if (idx == 0)            return 1'b0;
        if (idx <= DW)           return b[idx-1];
        if (pe != 0 && idx == DW + 1) return ^b;
        return 1'b1;
    endfunction

    // Waits (from a negedge) for the next start bit, counting tx-high cycles
    // before it, then checks the whole frame against the next queued byte.
    task automatic check_frame(input int d, output int gap, output logic par_obs);
        logic [7:0] b;
        int         fl;
        int         n;
        b   = mem[d][exp_idx[d]];
        exp_idx[d] = exp_idx[d] + 1;
        fl  = frame_bits(DW, d) * CPB;
        gap = 0;
        par_obs = 1'bx;
        n = 0;
        while (tx_w[d] && n < 400) begin
            @(negedge clk);
            gap++;
            n++;
        end
        chk("start_seen", int'(tx_w[d] == 1'b0), 1);
        if (tx_w[d]) return;
        for (int c = 0; c < fl; c++) begin
            if (d == 1 && c == (DW + 1) * CPB + CPB / 2) par_obs = tx_w[d];
            chk("tx_bit", tx_w[d], exp_bit(b, d, c / CPB));
            chk("busy_in_frame", busy_w[d], 1);
            chk("frame_done", fd_w[d], int'(c == fl - 1));
            @(negedge clk);
        end
        chk("tx_after_frame", tx_w[d], 1);
        chk("done_after_frame", fd_w[d], 0);
    endtask

    initial begin
        int   g;
        int   base;
        int   lows;
        int   nb;
        logic p;

        reset_L = 1'b0;
        en[0]   = 1'b1;
        en[1]   = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_tx", tx_w[d], 1);
            chk("rst_busy", busy_w[d], 0);
            chk("rst_done", fd_w[d], 0);
            chk("rst_rd", rd_w[d], 0);
        end
        reset_L = 1'b1;

        // Idle after reset with empty FIFO and enable high.
        lows = 0;
        base = rd_cnt[0] + rd_cnt[1];
        repeat (100) begin
            @(negedge clk);
            if (!tx_w[0] || !tx_w[1] || rd_w[0] || rd_w[1]) lows++;
        end
        chk("idle_activity", lows, 0);
        chk("idle_rd", rd_cnt[0] + rd_cnt[1] - base, 0);

        // Single byte, no parity.
        base = rd_cnt[0];
        push(0, 8'hA5);
        check_frame(0, g, p);
        repeat (5) @(negedge clk);
        chk("single_rd", rd_cnt[0] - base, 1);

        // Parity frames.
        push(1, 8'h03);
        push(1, 8'h07);
        check_frame(1, g, p);
        chk("parity_03", p, 0);
        check_frame(1, g, p);
        chk("parity_07", p, 1);
        chk("parity_gap", g, 3);

        // Back-to-back.
        base = rd_cnt[0];
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        check_frame(0, g, p);
        check_frame(0, g, p);
        chk("b2b_gap1", g, 3);
        check_frame(0, g, p);
        chk("b2b_gap2", g, 3);
        repeat (20) @(negedge clk);
        chk("b2b_rd", rd_cnt[0] - base, 3);

        // Enable dropped during DATA of the first frame.
        base = rd_cnt[0];
        push(0, 8'h44);
        push(0, 8'h55);
        push(0, 8'h66);
        fork
            check_frame(0, g, p);
            begin
                for (int i = 0; i < 400 && tx_w[0]; i++) @(negedge clk);
                repeat (10) @(negedge clk);
                en[0] = 1'b0;
            end
        join
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (!tx_w[0] || rd_w[0]) lows++;
        end
        chk("en_low_activity", lows, 0);
        chk("en_low_rd", rd_cnt[0] - base, 1);
        en[0] = 1'b1;
        check_frame(0, g, p);
        check_frame(0, g, p);
        chk("en_resume_gap", g, 3);
        chk("en_resume_rd", rd_cnt[0] - base, 3);

        // Reset asserted during data bit 3; that word is lost.
        base = rd_cnt[0];
        push(0, 8'h77);
        push(0, 8'h88);
        for (int i = 0; i < 400 && tx_w[0]; i++) @(negedge clk);
        chk("rst_mid_start", tx_w[0], 0);
        exp_idx[0] = exp_idx[0] + 1;
        repeat (CPB + 3 * CPB + 2) @(negedge clk);
        chk("pre_rst_tx_bit3", tx_w[0], 0);
        reset_L = 1'b0;
        #1;
        chk("rst_mid_tx", tx_w[0], 1);
        chk("rst_mid_busy", busy_w[0], 0);
        repeat (3) @(negedge clk);
        reset_L = 1'b1;
        #1;
        chk("rst_release_rd", rd_w[0], 0);
        check_frame(0, g, p);
        repeat (5) @(negedge clk);
        chk("rst_mid_rd", rd_cnt[0] - base, 2);

        // Randomized back-to-back bursts on both instances.
        for (int d = 0; d < 2; d++) begin
            nb = int'($urandom_range(3, 6));
            for (int k = 0; k < nb; k++) push(d, 8'($urandom_range(0, 255)));
            for (int k = 0; k < nb; k++) begin
                check_frame(d, g, p);
                if (k > 0) chk("rand_gap", g, 3);
            end
            repeat (10) @(negedge clk);
            chk("rand_fifo_drained", rd_ptr[d], wr_ptr[d]);
        end

        chk("no_rd_when_empty0", bad_rd[0], 0);
        chk("no_rd_when_empty1", bad_rd[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
